// File: rtl/wavelet_env_pkg.sv
// Shared types and helpers for the wavelet envelope tracker.
// Optional hold counters: define WAVELET_ENV_HOLD_EN.
package wavelet_env_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int SUM_TRUNCATION_DEF = 8;
  localparam int MAG_W = SUM_TRUNCATION_DEF - 1;

  // |s| clamped to the largest positive value of a w-bit signed word
  function automatic int unsigned sat_abs(
    input int s,
    input int w
  );
    int unsigned lim;
    int unsigned a;
    lim = (32'd1 << (w - 1)) - 32'd1;
    a = (s < 0) ? int'(-s) : s;
    if (a > lim) a = lim;
    return a;
  endfunction

endpackage

// File: rtl/wavelet_env_update.sv
// Single-channel envelope update, shared across the scan.
// Hold step exists only with WAVELET_ENV_HOLD_EN.
module wavelet_env_update
  import wavelet_env_pkg::*;
#(
  parameter int SUM_TRUNCATION = 8,
  parameter int DECAY_SHIFT = 4
`ifdef WAVELET_ENV_HOLD_EN
  ,
  parameter int HOLD_SAMPLES = 16,
  parameter int HOLD_W = 5
`endif
) (
  input  logic [SUM_TRUNCATION-1:0] sample,
  input  logic [SUM_TRUNCATION-2:0] env,
`ifdef WAVELET_ENV_HOLD_EN
  input  logic [HOLD_W-1:0]         hold,
  output logic [HOLD_W-1:0]         hold_next,
`endif
  output logic [SUM_TRUNCATION-2:0] env_next
);

  localparam int MW = SUM_TRUNCATION - 1;

  logic [MW-1:0] mag;
  logic [MW-1:0] dec;

  always_comb begin
    mag = MW'(sat_abs(int'($signed(sample)), SUM_TRUNCATION));
    dec = env >> DECAY_SHIFT;
    if (dec == '0) dec = MW'(1);
  end

  always_comb begin
    env_next = env;
`ifdef WAVELET_ENV_HOLD_EN
    hold_next = hold;
    if (mag >= env) begin
      env_next  = mag;
      hold_next = HOLD_W'(HOLD_SAMPLES);
    end else if (hold != '0) begin
      hold_next = hold - 1'b1;
    end else if (env != '0) begin
      env_next = env - dec;
    end
`else
    if (mag >= env) begin
      env_next = mag;
    end else if (env != '0) begin
      env_next = env - dec;
    end
`endif
  end

endmodule

// File: rtl/wavelet_envelope_tracker.sv
// Per-channel peak-hold/decay envelope, scanned one channel per cycle.
// Optional hold counters: define WAVELET_ENV_HOLD_EN.
module wavelet_envelope_tracker
  import wavelet_env_pkg::*;
#(
  parameter int NUM_FILTERS = 8,
  parameter int SUM_TRUNCATION = 8,
  parameter int DECAY_SHIFT = 4,
  parameter int HOLD_SAMPLES = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_FILTERS*SUM_TRUNCATION-1:0] i_wavelet,
  input  logic                                  i_sample_valid,
  input  logic [7:0]                            i_select_channel,
  output logic [SUM_TRUNCATION-1:0]             o_envelope,
  output logic                                  o_busy,
  output logic                                  o_update_done,
  output logic                                  o_overrun
);

  localparam int MW = SUM_TRUNCATION - 1;
  localparam int IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  state_t                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [SUM_TRUNCATION-1:0] snap_q [NUM_FILTERS];
  logic [MW-1:0]             env_q  [NUM_FILTERS];
  logic [MW-1:0]             env_nx;
  logic                      last;

`ifdef WAVELET_ENV_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
  logic [HOLD_W-1:0] hold_q [NUM_FILTERS];
  logic [HOLD_W-1:0] hold_nx;
`endif

  assign last = (idx_q == IDX_W'(NUM_FILTERS - 1));
  assign o_busy = (state_q == SCAN);

  wavelet_env_update #(
    .SUM_TRUNCATION(SUM_TRUNCATION),
    .DECAY_SHIFT   (DECAY_SHIFT)
`ifdef WAVELET_ENV_HOLD_EN
    ,
    .HOLD_SAMPLES  (HOLD_SAMPLES),
    .HOLD_W        (HOLD_W)
`endif
  ) u_update (
    .sample   (snap_q[idx_q]),
    .env      (env_q[idx_q]),
`ifdef WAVELET_ENV_HOLD_EN
    .hold     (hold_q[idx_q]),
    .hold_next(hold_nx),
`endif
    .env_next (env_nx)
  );

  // Snapshot is only meaningful during SCAN, so it needs no reset
  always_ff @(posedge clk) begin
    if (state_q == IDLE && i_sample_valid) begin
      for (int k = 0; k < NUM_FILTERS; k++) begin
        snap_q[k] <= i_wavelet[k*SUM_TRUNCATION +: SUM_TRUNCATION];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      o_update_done <= 1'b0;
      o_overrun     <= 1'b0;
      for (int k = 0; k < NUM_FILTERS; k++) begin
        env_q[k] <= '0;
`ifdef WAVELET_ENV_HOLD_EN
        hold_q[k] <= '0;
`endif
      end
    end else begin
      o_update_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_sample_valid) begin
            state_q <= SCAN;
            idx_q   <= '0;
          end
        end
        SCAN: begin
          env_q[idx_q] <= env_nx;
`ifdef WAVELET_ENV_HOLD_EN
          hold_q[idx_q] <= hold_nx;
`endif
          if (i_sample_valid) o_overrun <= 1'b1;
          if (last) begin
            state_q       <= IDLE;
            o_update_done <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_envelope <= '0;
    end else if (int'(i_select_channel) < NUM_FILTERS) begin
      o_envelope <= {1'b0, env_q[i_select_channel[IDX_W-1:0]]};
    end else begin
      o_envelope <= '0;
    end
  end

endmodule
